csa_accum_seq: RTL and testbench

Sequencer that reduces a burst of LEN 32-bit operands to one sum using a single shared 3-input, 33-bit-result adder (a, b, c -> sum[32:0]) instantiated beside it. Each accepted beat supplies two new operands; the block feeds its running accumulator as the third adder input, so one beat is reduced per cycle. It sits between an operand-stream producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/csa_accum_seq_if.sv | 27 ++
 rtl/csa_accum_seq.sv | 102 ++++++++++
 tb/tb_csa_accum_seq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_accum_seq_if.sv
// Handshake bundle for csa_accum_seq: burst control, operand stream and result stream.
// master drives operands and consumes results; slave is the sequencer.
interface csa_accum_seq_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic             res_ovf;

  modport master (
    output start, len, abort, in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data, res_ovf
  );

  modport slave (
    input  start, len, abort, in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/csa_accum_seq.sv
// Burst reduction sequencer: folds two operands per accepted beat into a running sum
// through an external shared 3-input adder, then hands one result downstream.
//
// state | meaning
// IDLE  | waiting for start; no handshakes open
// RUN   | accepting beats, one adder step per accepted beat
// DONE  | result held on res_* until consumed or aborted
module csa_accum_seq #(
  parameter int LEN_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  csa_accum_seq_if.slave      bus,
  output logic [31:0]         add_a,
  output logic [31:0]         add_b,
  output logic [31:0]         add_c,
  input  logic [32:0]         add_sum,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      acc;
  logic             ovf;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] rem_next;
  logic             fire;
  logic             last;

  // Final beat of an odd burst carries only one operand.
  assign last     = (remaining == LEN_W'(1));
  assign rem_next = remaining - (last ? LEN_W'(1) : LEN_W'(2));
  assign fire     = (state == RUN) && !bus.abort && bus.in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (fire && (rem_next == '0)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.abort || bus.res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == RUN) && !bus.abort;
    bus.res_valid = (state == DONE);
    bus.res_data  = (state == DONE) ? acc : 32'd0;
    bus.res_ovf   = (state == DONE) && ovf;
    busy          = (state != IDLE);
    add_a         = fire ? bus.in_a : 32'd0;
    add_b         = (fire && !last) ? bus.in_b : 32'd0;
    add_c         = acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= 32'd0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        acc       <= 32'd0;
        ovf       <= 1'b0;
        remaining <= bus.len;
      end
    end else if (fire) begin
      acc       <= add_sum[31:0];
      ovf       <= ovf | add_sum[32];
      remaining <= rem_next;
    end
  end

endmodule

// File: tb/tb_csa_accum_seq.sv
// Self-checking bench for csa_accum_seq with a behavioural shared adder and result scoreboard.
module tb_csa_accum_seq;
  localparam int LEN_W = 8;

  logic        clk;
  logic        rst;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_c;
  logic [32:0] add_sum;
  logic        busy;

  int n_tests;
  int n_fail;

  logic [32:0] exp_q[$];
  logic [31:0] m_acc;
  logic        m_ovf;

  csa_accum_seq_if #(.LEN_W(LEN_W)) bus ();

  csa_accum_seq #(.LEN_W(LEN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_c   (add_c),
    .add_sum (add_sum),
    .busy    (busy)
  );

  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {1'b0, add_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_burst(input logic [LEN_W-1:0] n, input logic [31:0] exp_d, input logic exp_o);
    bus.start = 1'b1;
    bus.len   = n;
    exp_q.push_back({exp_o, exp_d});
    m_acc = 32'd0;
    m_ovf = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.len   = '0;
  endtask

  // Drives one beat after `gap` idle cycles, checks adder drive while it is accepted.
  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic odd_last, input int gap);
    logic [32:0] s;
    int          w;
    for (int i = 0; i < gap; i++) begin
      tick();
      chk("acc_hold_in_gap", {32'd0, add_c}, {32'd0, m_acc});
    end
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    #1;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      tick();
      #1;
      w++;
    end
    chk("beat_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("beat_add_a", {32'd0, add_a}, {32'd0, a});
    chk("beat_add_b", {32'd0, add_b}, odd_last ? 64'd0 : {32'd0, b});
    chk("beat_add_c", {32'd0, add_c}, {32'd0, m_acc});
    s     = {1'b0, m_acc} + {1'b0, a} + (odd_last ? 33'd0 : {1'b0, b});
    m_acc = s[31:0];
    m_ovf = m_ovf | s[32];
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = 32'd0;
    bus.in_b     = 32'd0;
  endtask

  // Called one cycle after the final beat (or start for len=0): result must be up now.
  task automatic collect(input int hold);
    logic [32:0] e;
    int          w;
    chk("res_latency", {63'd0, bus.res_valid}, 64'd1);
    w = 0;
    while (!bus.res_valid && w < 20) begin
      tick();
      w++;
    end
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q[0];
    for (int i = 0; i < hold; i++) begin
      chk("res_stable_valid", {63'd0, bus.res_valid}, 64'd1);
      chk("res_stable_data", {32'd0, bus.res_data}, {32'd0, e[31:0]});
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    e = exp_q.pop_front();
    chk("res_data", {32'd0, bus.res_data}, {32'd0, e[31:0]});
    chk("res_ovf", {63'd0, bus.res_ovf}, {63'd0, e[32]});
    chk("model_acc", {32'd0, bus.res_data}, {32'd0, m_acc});
    tick();
    bus.res_ready = 1'b0;
    chk("res_valid_drop", {63'd0, bus.res_valid}, 64'd0);
    chk("idle_after_res", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    m_acc         = 32'd0;
    m_ovf         = 1'b0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_res_valid", {63'd0, bus.res_valid}, 64'd0);
    chk("rst_res_data", {32'd0, bus.res_data}, 64'd0);
    chk("rst_res_ovf", {63'd0, bus.res_ovf}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    tick();

    // abort ignored in IDLE, in_ready stays low
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("idle_abort_busy", {63'd0, busy}, 64'd0);

    // len=4 back-to-back
    start_burst(8'd4, 32'd100, 1'b0);
    chk("run_busy", {63'd0, busy}, 64'd1);
    beat(32'd10, 32'd20, 1'b0, 0);
    beat(32'd30, 32'd40, 1'b0, 0);
    collect(0);

    // len=3, odd final beat ignores in_b
    start_burst(8'd3, 32'd6, 1'b0);
    beat(32'd1, 32'd2, 1'b0, 0);
    beat(32'd3, 32'hDEADBEEF, 1'b1, 0);
    collect(1);

    // overflow, then sticky overflow with wrap to zero
    start_burst(8'd2, 32'd1, 1'b1);
    beat(32'hFFFFFFFF, 32'd2, 1'b0, 0);
    collect(0);
    start_burst(8'd4, 32'd5, 1'b1);
    beat(32'hFFFFFFFF, 32'd1, 1'b0, 0);
    beat(32'd5, 32'd0, 1'b0, 0);
    collect(0);

    // len=0 goes straight to DONE
    start_burst(8'd0, 32'd0, 1'b0);
    chk("len0_in_ready", {63'd0, bus.in_ready}, 64'd0);
    collect(2);

    // backpressure on both sides
    start_burst(8'd4, 32'd100, 1'b0);
    beat(32'd10, 32'd20, 1'b0, 3);
    beat(32'd30, 32'd40, 1'b0, 3);
    collect(5);

    // start ignored while running
    start_burst(8'd2, 32'd3, 1'b0);
    bus.start = 1'b1;
    bus.len   = 8'd6;
    tick();
    bus.start = 1'b0;
    bus.len   = '0;
    beat(32'd1, 32'd2, 1'b0, 0);
    collect(0);

    // abort in RUN while a beat is presented
    start_burst(8'd6, 32'd0, 1'b0);
    beat(32'd1, 32'd2, 1'b0, 0);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'd3;
    bus.in_b     = 32'd4;
    bus.abort    = 1'b1;
    #1;
    chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("abort_add_a", {32'd0, add_a}, 64'd0);
    tick();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_idle", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_res", {63'd0, bus.res_valid}, 64'd0);
    end

    // abort beats res handshake in DONE
    start_burst(8'd2, 32'd2, 1'b0);
    beat(32'd1, 32'd1, 1'b0, 0);
    chk("done_valid", {63'd0, bus.res_valid}, 64'd1);
    bus.abort     = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    bus.abort     = 1'b0;
    bus.res_ready = 1'b0;
    void'(exp_q.pop_back());
    chk("done_abort_valid", {63'd0, bus.res_valid}, 64'd0);
    chk("done_abort_busy", {63'd0, busy}, 64'd0);

    // async reset while holding a result
    start_burst(8'd2, 32'd18, 1'b0);
    beat(32'd9, 32'd9, 1'b0, 0);
    chk("pre_rst_data", {32'd0, bus.res_data}, 64'd18);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {63'd0, bus.res_valid}, 64'd0);
    chk("async_rst_data", {32'd0, bus.res_data}, 64'd0);
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    void'(exp_q.pop_back());
    tick();
    rst = 1'b0;
    tick();

    // fresh burst after reset
    start_burst(8'd2, 32'd15, 1'b0);
    beat(32'd7, 32'd8, 1'b0, 0);
    collect(0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
